// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV threshold / centroid block: FSM states,
// mask output codes and the hue window test.
package hsv_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    START  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] MASK_ON  = 8'hFF;
  localparam logic [7:0] MASK_OFF = 8'h00;
  localparam logic [7:0] MARKER   = 8'h80;

  // A window with h_min > h_max wraps through 0 (red hues straddle 255/0).
  function automatic logic hue_in_window(input logic [7:0] h,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (lo <= hi) return (h >= lo) && (h <= hi);
    else          return (h >= lo) || (h <= hi);
  endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
// done is high during the cycle whose edge writes the final quotient bit.
module seq_div #(
  parameter int N_W = 32,
  parameter int D_W = 21,
  parameter int LAT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient,
  output logic           done
);

  localparam int CW = $clog2(LAT + 1);

  logic [D_W-1:0] rem;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic [D_W:0]   rem_sh;
  logic [D_W+1:0] diff;
  logic           ge;

  always_comb begin
    rem_sh = {rem, quotient[N_W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, divisor};
    ge     = (diff[D_W+1:D_W] == 2'b00);
    done   = busy && (cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (ce) begin
      if (start) begin
        rem      <= '0;
        quotient <= dividend;
        cnt      <= CW'(LAT);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= ge ? diff[D_W-1:0] : rem_sh[D_W-1:0];
        quotient <= {quotient[N_W-2:0], ge};
        cnt      <= cnt - CW'(1);
        if (cnt == CW'(1)) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hsv_centroid.sv
// HSV colour threshold with per-frame centroid of in-range pixels.
// Optional macro HSV_CENTROID_MARKER_EN draws the last centroid as a crosshair.
module hsv_centroid
  import hsv_pkg::*;
#(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int SUM_W   = 32,
  parameter int CNT_W   = 21,
  parameter int DIV_LAT = SUM_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic [7:0]     H,
  input  logic [7:0]     S,
  input  logic [7:0]     V,
  input  logic           in_hsync,
  input  logic           in_vsync,
  input  logic           in_de,
  input  logic [7:0]     h_min,
  input  logic [7:0]     h_max,
  input  logic [7:0]     s_min,
  input  logic [7:0]     v_min,
  output logic [7:0]     mask,
  output logic           out_hsync,
  output logic           out_vsync,
  output logic           out_de,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           found,
  output logic           res_valid,
  output logic           overrun
);

  state_t             state;
  logic               prev_de, prev_vsync;
  logic               de_fall, vsync_rise;
  logic [X_W-1:0]     x_cnt;
  logic [Y_W-1:0]     y_cnt, y_cur;
  logic               hit;
  logic [7:0]         mask_nxt;
  logic [SUM_W-1:0]   sum_x, sum_y, base_x, base_y, sum_x_nxt, sum_y_nxt;
  logic [CNT_W-1:0]   count, base_cnt, count_nxt;
  logic [SUM_W:0]     add_x, add_y;
  logic [CNT_W:0]     add_cnt;
  logic [SUM_W-1:0]   lat_sx, lat_sy;
  logic [CNT_W-1:0]   lat_cnt;
  logic [SUM_W-1:0]   q_x, q_y;
  logic               div_start, done_x, done_y;

  assign de_fall    = prev_de & ~in_de;
  assign vsync_rise = in_vsync & ~prev_vsync;
  // A pixel arriving with the vsync edge belongs to row 0 of the new frame.
  assign y_cur      = vsync_rise ? '0 : y_cnt;
  assign hit        = in_de && (S >= s_min) && (V >= v_min) && hue_in_window(H, h_min, h_max);
  assign div_start  = (state == START) && (lat_cnt != '0);

  always_comb begin
    mask_nxt = MASK_OFF;
    if (hit) mask_nxt = MASK_ON;
`ifdef HSV_CENTROID_MARKER_EN
    else if (in_de && found && ((x_cnt == cx) || (y_cur == cy))) mask_nxt = MARKER;
`endif
  end

  always_comb begin
    base_x    = vsync_rise ? '0 : sum_x;
    base_y    = vsync_rise ? '0 : sum_y;
    base_cnt  = vsync_rise ? '0 : count;
    add_x     = {1'b0, base_x} + {{(SUM_W + 1 - X_W){1'b0}}, x_cnt};
    add_y     = {1'b0, base_y} + {{(SUM_W + 1 - Y_W){1'b0}}, y_cur};
    add_cnt   = {1'b0, base_cnt} + (CNT_W + 1)'(1);
    sum_x_nxt = base_x;
    sum_y_nxt = base_y;
    count_nxt = base_cnt;
    if (hit) begin
      sum_x_nxt = add_x[SUM_W] ? '1 : add_x[SUM_W-1:0];
      sum_y_nxt = add_y[SUM_W] ? '1 : add_y[SUM_W-1:0];
      count_nxt = add_cnt[CNT_W] ? '1 : add_cnt[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask       <= MASK_OFF;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_de     <= 1'b0;
      prev_de    <= 1'b0;
      prev_vsync <= 1'b0;
    end else if (ce) begin
      mask       <= mask_nxt;
      out_hsync  <= in_hsync;
      out_vsync  <= in_vsync;
      out_de     <= in_de;
      prev_de    <= in_de;
      prev_vsync <= in_vsync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if (ce) begin
      if (in_de) begin
        if (x_cnt != '1) x_cnt <= x_cnt + X_W'(1);
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (vsync_rise)                y_cnt <= '0;
      else if (de_fall && y_cnt != '1) y_cnt <= y_cnt + Y_W'(1);
      sum_x <= sum_x_nxt;
      sum_y <= sum_y_nxt;
      count <= count_nxt;
    end
  end

  // Frames that end while a result is still being computed are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      lat_sx    <= '0;
      lat_sy    <= '0;
      lat_cnt   <= '0;
      cx        <= '0;
      cy        <= '0;
      found     <= 1'b0;
      overrun   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= ce && (state == DONE);
      if (ce) begin
        if (vsync_rise && state != ACCUM) overrun <= 1'b1;
        case (state)
          ACCUM: if (vsync_rise) begin
            lat_sx  <= sum_x;
            lat_sy  <= sum_y;
            lat_cnt <= count;
            state   <= START;
          end
          START:  state <= (lat_cnt == '0) ? DONE : DIVIDE;
          DIVIDE: if (done_x && done_y) state <= DONE;
          DONE: begin
            found <= (lat_cnt != '0);
            if (lat_cnt != '0) begin
              cx <= (|q_x[SUM_W-1:X_W]) ? '1 : q_x[X_W-1:0];
              cy <= (|q_y[SUM_W-1:Y_W]) ? '1 : q_y[Y_W-1:0];
            end
            state <= ACCUM;
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

  seq_div #(.N_W(SUM_W), .D_W(CNT_W), .LAT(DIV_LAT)) u_div_x (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(div_start),
    .dividend(lat_sx), .divisor(lat_cnt), .quotient(q_x), .done(done_x)
  );

  seq_div #(.N_W(SUM_W), .D_W(CNT_W), .LAT(DIV_LAT)) u_div_y (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(div_start),
    .dividend(lat_sy), .divisor(lat_cnt), .quotient(q_y), .done(done_y)
  );

endmodule

// File: tb/tb_hsv_centroid.sv
// Directed bench for hsv_centroid: hue window, centroid timing, empty frame,
// overrun, clock-enable stall and reset during division.
module tb_hsv_centroid;

  localparam int X_W = 11, Y_W = 10, SUM_W = 32, CNT_W = 21, DIV_LAT = 32;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
  logic [7:0] H = '0, S = '0, V = '0;
  logic in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
  logic [7:0] h_min = '0, h_max = '0, s_min = '0, v_min = '0;
  logic [7:0] mask;
  logic out_hsync, out_vsync, out_de, found, res_valid, overrun;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  int checks = 0;
  int failures = 0;
  int n;
  logic saw_valid;

  hsv_centroid #(.X_W(X_W), .Y_W(Y_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .H(H), .S(S), .V(V),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .h_min(h_min), .h_max(h_max), .s_min(s_min), .v_min(v_min),
    .mask(mask), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
    .cx(cx), .cy(cy), .found(found), .res_valid(res_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                               input logic de, input logic hs, input logic vs);
    H = h; S = s; V = v; in_de = de; in_hsync = hs; in_vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    H = '0; S = '0; V = '0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // 8x4 frame; pixels (ax,ay) and (bx,by) are in range (V=255), others V=0.
  task automatic send_frame(input int ax, input int ay, input int bx, input int by, input int stall_x);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        logic hit;
        hit = ((x == ax) && (y == ay)) || ((x == bx) && (y == by));
        applyStimulus(8'd0, 8'd0, hit ? 8'd255 : 8'd0, 1'b1, 1'b0, 1'b0);
        if (y == 0 && x == stall_x) begin
          checkOutput("stall_pre_mask", {24'd0, mask}, 32'hFF);
          ce = 1'b0;
          for (int k = 0; k < 5; k++) begin
            applyStimulus(8'd99, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
            checkOutput("stall_mask", {24'd0, mask}, 32'hFF);
            checkOutput("stall_out_de", {31'd0, out_de}, 32'd1);
            checkOutput("stall_out_vsync", {31'd0, out_vsync}, 32'd0);
          end
          ce = 1'b1;
        end
      end
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      cycles++;
    end while (!res_valid && cycles < 300);
    checkOutput("res_valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    #3;
    checkOutput("rst_mask", {24'd0, mask}, 32'd0);
    checkOutput("rst_cx", {21'd0, cx}, 32'd0);
    checkOutput("rst_cy", {22'd0, cy}, 32'd0);
    checkOutput("rst_found", {31'd0, found}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
    do_reset();

    // Hue window wrapping through zero.
    h_min = 8'd240; h_max = 8'd10; s_min = 8'd0; v_min = 8'd0;
    applyStimulus(8'd250, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_h250", {24'd0, mask}, 32'hFF);
    checkOutput("wrap_out_de", {31'd0, out_de}, 32'd1);
    applyStimulus(8'd5, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_h5", {24'd0, mask}, 32'hFF);
    applyStimulus(8'd100, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_h100", {24'd0, mask}, 32'h00);
    applyStimulus(8'd240, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_h240", {24'd0, mask}, 32'hFF);
    applyStimulus(8'd11, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_h11", {24'd0, mask}, 32'h00);
    applyStimulus(8'd250, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("no_de_mask", {24'd0, mask}, 32'h00);
    checkOutput("no_de_hsync", {31'd0, out_hsync}, 32'd1);

    // Plain window plus saturation/value thresholds.
    h_min = 8'd20; h_max = 8'd40; s_min = 8'd100; v_min = 8'd50;
    applyStimulus(8'd20, 8'd100, 8'd50, 1'b1, 1'b0, 1'b0);
    checkOutput("win_lo_edge", {24'd0, mask}, 32'hFF);
    applyStimulus(8'd41, 8'd200, 8'd200, 1'b1, 1'b0, 1'b0);
    checkOutput("win_h41", {24'd0, mask}, 32'h00);
    applyStimulus(8'd30, 8'd99, 8'd200, 1'b1, 1'b0, 1'b0);
    checkOutput("win_s_low", {24'd0, mask}, 32'h00);
    applyStimulus(8'd30, 8'd200, 8'd49, 1'b1, 1'b0, 1'b0);
    checkOutput("win_v_low", {24'd0, mask}, 32'h00);
    do_reset();

    // Centroid of (2,1) and (4,3) is (3,2).
    h_min = 8'd0; h_max = 8'd255; s_min = 8'd0; v_min = 8'd200;
    send_frame(2, 1, 4, 3, -1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("vsync_out", {31'd0, out_vsync}, 32'd1);
    wait_result(n);
    checkOutput("centroid_latency", n, DIV_LAT + 2);
    checkOutput("centroid_cx", {21'd0, cx}, 32'd3);
    checkOutput("centroid_cy", {22'd0, cy}, 32'd2);
    checkOutput("centroid_found", {31'd0, found}, 32'd1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("res_valid_pulse", {31'd0, res_valid}, 32'd0);

    // Empty frame keeps previous centroid.
    send_frame(-1, -1, -1, -1, -1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    wait_result(n);
    checkOutput("empty_latency", n, 2);
    checkOutput("empty_found", {31'd0, found}, 32'd0);
    checkOutput("empty_cx", {21'd0, cx}, 32'd3);
    checkOutput("empty_cy", {22'd0, cy}, 32'd2);

    // Second vsync edge while dividing.
    send_frame(2, 1, 4, 3, -1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (10) applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("overrun_before", {31'd0, overrun}, 32'd0);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
    wait_result(n);
    checkOutput("overrun_latency", n, DIV_LAT + 2 - 11);
    checkOutput("overrun_cx", {21'd0, cx}, 32'd3);
    checkOutput("overrun_cy", {22'd0, cy}, 32'd2);
    checkOutput("overrun_found", {31'd0, found}, 32'd1);
    repeat (5) applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Clock-enable stall mid-line; (5,0),(1,2) -> (3,1).
    send_frame(5, 0, 1, 2, 5);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    wait_result(n);
    checkOutput("stall_latency", n, DIV_LAT + 2);
    checkOutput("stall_cx", {21'd0, cx}, 32'd3);
    checkOutput("stall_cy", {22'd0, cy}, 32'd1);

    // Reset during division; (7,3),(1,1) -> (4,2).
    send_frame(7, 3, 1, 1, -1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (10) applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cx", {21'd0, cx}, 32'd0);
    checkOutput("midrst_cy", {22'd0, cy}, 32'd0);
    checkOutput("midrst_found", {31'd0, found}, 32'd0);
    checkOutput("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("midrst_out_hsync", {31'd0, out_hsync}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      saw_valid = saw_valid | res_valid;
    end
    checkOutput("midrst_no_valid", {31'd0, saw_valid}, 32'd0);
    send_frame(7, 3, 1, 1, -1);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    wait_result(n);
    checkOutput("after_rst_cx", {21'd0, cx}, 32'd4);
    checkOutput("after_rst_cy", {22'd0, cy}, 32'd2);
    checkOutput("after_rst_found", {31'd0, found}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hsv_centroid.md
HSV_CENTROID -- requirements
Module: hsv_centroid

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X_W, 11, column counter width.
- Y_W, 10, row counter width.
- SUM_W, 32, coordinate accumulator width.
- CNT_W, 21, pixel-count width.
- DIV_LAT, SUM_W, divider iterations.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- ce, in, 1, clock enable.
- H, S, V, in, 8 each, pixel from HSV stage.
- in_hsync, in_vsync, in_de, in, 1 each, syncs aligned with H/S/V.
- h_min, h_max, s_min, v_min, in, 8 each, thresholds, quasi-static.
- mask, out, 8, 8'hFF if pixel in range, else 8'h00.
- out_hsync, out_vsync, out_de, out, 1 each, syncs aligned with mask.
- cx, out, X_W, centroid column.
- cy, out, Y_W, centroid row.
- found, out, 1, last result had nonzero count.
- res_valid, out, 1, one-cycle result strobe.
- overrun, out, 1, sticky frame-drop flag.

Function
REQ-003 Sequential state SHALL advance only when ce=1; divider included.
REQ-004 Pixel in range iff S>=s_min, V>=v_min and hue test true.
REQ-005 Hue test: h_min<=h_max -> h_min<=H<=h_max; h_min>h_max -> H>=h_min or H<=h_max (wrap).
REQ-006 mask and out_* SHALL be registered, latency exactly 1 ce-cycle; mask=0 when in_de=0.
REQ-007 Column x: 0 at first de pixel, +1 per de pixel, saturates at 2^X_W-1, cleared on in_de falling edge.
REQ-008 Row y: +1 on each in_de falling edge, saturates at 2^Y_W-1, cleared on in_vsync rising edge.
REQ-009 Each in-range de pixel SHALL add x to sum_x, y to sum_y, 1 to count; all three saturate at maximum.
REQ-010 FSM states: ACCUM, START, DIVIDE, DONE; reset state ACCUM.
REQ-011 ACCUM -> START on in_vsync rising edge: latch sum_x, sum_y, count; clear accumulators same cycle.
REQ-012 START: latched count=0 -> DONE with found=0; else launch both divisions -> DIVIDE.
REQ-013 DIVIDE: cx=sum_x/count, cy=sum_y/count, truncated, both in parallel; -> DONE after DIV_LAT ce-cycles.
REQ-014 DONE: update cx, cy, found; pulse res_valid for one cycle; -> ACCUM.
REQ-015 found=0: cx, cy SHALL hold previous values.
REQ-016 Accumulation SHALL continue in every state.
REQ-017 vsync rising edge outside ACCUM: frame dropped, accumulators still cleared, overrun set.
REQ-018 In-range pixel coincident with vsync rising edge SHALL count toward the new frame.

Reset
REQ-019 rst_n low SHALL asynchronously zero every register and output; FSM -> ACCUM.
REQ-020 Reset mid-DIVIDE SHALL abort division; no res_valid pulse.
REQ-021 overrun clears only by reset.

Configuration
REQ-022 Macro HSV_CENTROID_MARKER_EN defined: out-of-range pixels with x==cx or y==cy output 8'h80, but only while found=1 (last centroid marker).
REQ-023 Macro undefined: mask strictly 8'hFF/8'h00; marker logic absent.

Structure
REQ-024 Package hsv_pkg SHALL hold the FSM state enum and MASK_ON=8'hFF, MASK_OFF=8'h00, MARKER=8'h80.
REQ-025 Sub-module seq_div: unsigned restoring divider, SUM_W/CNT_W, start/done handshake, instantiated twice.

Verification
REQ-026 Benches SHALL cover:
- Hue wrap: h_min=240, h_max=10, s_min=v_min=0; H=250 -> mask FF; H=5 -> FF; H=100 -> 00.
- Centroid: 8x4 frame, pixels (2,1), (4,3) in range, vsync -> after DIV_LAT+2 cycles res_valid, cx=3, cy=2, found=1.
- Empty frame: no in-range pixels -> res_valid, found=0, cx/cy unchanged.
- Overrun: second vsync edge during DIVIDE -> overrun=1, first result still delivered.
- ce low 5 cycles mid-line -> mask/syncs frozen; result equals ce-always-high run.
- Reset mid-DIVIDE -> all outputs 0, no res_valid; next frame correct.
